// File: rtl/serv_ser_bridge_if.sv
// Handshake and serial bus bundle between the operand/result producer-consumer
// and serv_ser_bridge. The bridge uses the slave modport, the driving side the
// master modport.
//   start : i_start_valid / o_start_ready with i_rs1, i_rs2, i_imm payload
//   serial: o_rs1, o_rs2, o_imm, o_en, o_cnt0, o_cnt_done out; i_rd, i_cmp in
//   result: o_rd_valid / i_rd_ready with o_rd, o_cmp payload
interface serv_ser_bridge_if;
   localparam int unsigned W = 32;

   logic         i_start_valid;
   logic         o_start_ready;
   logic [W-1:0] i_rs1;
   logic [W-1:0] i_rs2;
   logic [W-1:0] i_imm;

   logic         o_rs1;
   logic         o_rs2;
   logic         o_imm;
   logic         o_en;
   logic         o_cnt0;
   logic         o_cnt_done;
   logic         i_rd;
   logic         i_cmp;

   logic         o_rd_valid;
   logic         i_rd_ready;
   logic [W-1:0] o_rd;
   logic         o_cmp;

   modport slave (
      input  i_start_valid, i_rs1, i_rs2, i_imm, i_rd, i_cmp, i_rd_ready,
      output o_start_ready, o_rs1, o_rs2, o_imm, o_en, o_cnt0, o_cnt_done,
             o_rd_valid, o_rd, o_cmp
   );

   modport master (
      output i_start_valid, i_rs1, i_rs2, i_imm, i_rd, i_cmp, i_rd_ready,
      input  o_start_ready, o_rs1, o_rs2, o_imm, o_en, o_cnt0, o_cnt_done,
             o_rd_valid, o_rd, o_cmp
   );
endinterface

// File: rtl/serv_ser_bridge.sv
// Parallel-to-serial operand bridge and serial-to-parallel result collector
// for the bit-serial ALU. Accepts one operand set, streams it LSB-first for
// 32 cycles with the ALU strobes, gathers the serial result and compare flag,
// and holds the parallel result until the consumer takes it.
// Ports:
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : serv_ser_bridge_if.slave (start handshake, serial ALU side,
//              result handshake)
module serv_ser_bridge (
   input logic             clk,
   input logic             i_rst_n,
   serv_ser_bridge_if.slave bus
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [W-1:0]  rs1_q,   rs1_d;
   logic [W-1:0]  rs2_q,   rs2_d;
   logic [W-1:0]  imm_q,   imm_d;
   logic [W-1:0]  res_q,   res_d;
   logic          cmp_q,   cmp_d;
   logic          run;

   // State and datapath registers
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         cmp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         imm_q   <= imm_d;
         res_q   <= res_d;
         cmp_q   <= cmp_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      res_d   = res_q;
      cmp_d   = cmp_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_start_valid) begin
               rs1_d   = bus.i_rs1;
               rs2_d   = bus.i_rs2;
               imm_d   = bus.i_imm;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            rs1_d = {1'b0, rs1_q[W-1:1]};
            rs2_d = {1'b0, rs2_q[W-1:1]};
            imm_d = {1'b0, imm_q[W-1:1]};
            // Result enters at the MSB so bit k sampled at cnt==k ends at res[k]
            res_d = {bus.i_rd, res_q[W-1:1]};
            if (cnt_q == CNT_LAST) begin
               cmp_d   = bus.i_cmp;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_HOLD: begin
            // Returning to IDLE only; a start cannot be taken in this cycle
            if (bus.i_rd_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only
   assign run               = (state_q == ST_RUN);
   assign bus.o_start_ready = (state_q == ST_IDLE);
   assign bus.o_en          = run;
   assign bus.o_rs1         = run & rs1_q[0];
   assign bus.o_rs2         = run & rs2_q[0];
   assign bus.o_imm         = run & imm_q[0];
   assign bus.o_cnt0        = run & (cnt_q == '0);
   assign bus.o_cnt_done    = run & (cnt_q == CNT_LAST);
   assign bus.o_rd_valid    = (state_q == ST_HOLD);
   assign bus.o_rd          = res_q;
   assign bus.o_cmp         = cmp_q;

endmodule

// File: tb/tb_serv_ser_bridge.sv
// Self-checking bench for serv_ser_bridge: a cycle-level operation model
// (phase of the current operation, operands captured, result bits gathered by
// index) checked every cycle, plus directed literal checks per scenario.
module tb_serv_ser_bridge;

   logic        clk;
   logic        rst_n;
   logic        loop_en;
   logic        rd_drv;

   int          total;
   int          bad;

   serv_ser_bridge_if bus_if ();

   serv_ser_bridge u_dut (
      .clk    (clk),
      .i_rst_n(rst_n),
      .bus    (bus_if)
   );

   assign bus_if.i_rd = loop_en ? bus_if.o_rs1 : rd_drv;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase 0: waiting for start; 1..32: serial cycle number; 33: result held
   int          phase;
   logic [31:0] m_rs1, m_rs2, m_imm, m_rd;
   logic        m_cmp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 0;
         m_rd  <= '0;
         m_cmp <= 1'b0;
      end else if (phase == 0) begin
         if (bus_if.i_start_valid) begin
            m_rs1 <= bus_if.i_rs1;
            m_rs2 <= bus_if.i_rs2;
            m_imm <= bus_if.i_imm;
            phase <= 1;
         end
      end else if (phase <= 32) begin
         m_rd[phase-1] <= loop_en ? m_rs1[phase-1] : rd_drv;
         if (phase == 32) m_cmp <= bus_if.i_cmp;
         phase <= phase + 1;
      end else if (bus_if.i_rd_ready) begin
         phase <= 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit e_run;
   int e_idx;
   always @(negedge clk) begin
      e_run = (phase >= 1) && (phase <= 32);
      e_idx = e_run ? phase - 1 : 0;
      chk1("start_ready", bus_if.o_start_ready, phase == 0);
      chk1("en",          bus_if.o_en,          e_run);
      chk1("cnt0",        bus_if.o_cnt0,        phase == 1);
      chk1("cnt_done",    bus_if.o_cnt_done,    phase == 32);
      chk1("rs1_bit",     bus_if.o_rs1,         e_run && m_rs1[e_idx]);
      chk1("rs2_bit",     bus_if.o_rs2,         e_run && m_rs2[e_idx]);
      chk1("imm_bit",     bus_if.o_imm,         e_run && m_imm[e_idx]);
      chk1("rd_valid",    bus_if.o_rd_valid,    phase == 33);
      if (phase == 33 || !rst_n) begin
         chk32("rd_word", bus_if.o_rd,  m_rd);
         chk1 ("cmp",     bus_if.o_cmp, m_cmp);
      end
   end

   // ---------------- directed operation driver ----------------
   int          r_en, r_lat, r_cnt0, r_cnt0_at, r_done, r_done_at, r_rdy_hold;
   logic [31:0] r_rs2, r_imm, r_rd;
   logic        r_cmp, r_stable, r_rdy_after;

   // Drives one operation; cycle c=1 is the first cycle after the accepting edge.
   // cmp_mode: 0 none, 1 high only in cycle 32, 2 high in all cycles but 32.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pat,
                         input bit loop, input int cmp_mode,
                         input int hold_extra, input bit keep_valid);
      int c;
      bit seen_valid;
      r_en = 0; r_lat = 0; r_cnt0 = 0; r_cnt0_at = 0; r_done = 0; r_done_at = 0;
      r_rdy_hold = 0; r_rs2 = '0; r_imm = '0; r_rd = '0; r_cmp = 1'b0;
      r_stable = 1'b1; seen_valid = 1'b0;
      @(posedge clk); #2;
      bus_if.i_start_valid = 1'b1;
      bus_if.i_rs1 = a; bus_if.i_rs2 = b; bus_if.i_imm = im;
      bus_if.i_rd_ready = 1'b0; bus_if.i_cmp = 1'b0;
      loop_en = loop; rd_drv = 1'b0;
      @(posedge clk); #2;
      c = 1;
      while (c <= 33 + hold_extra) begin
         if (!keep_valid) bus_if.i_start_valid = 1'b0;
         bus_if.i_rs1 = ~a ^ 32'(c); bus_if.i_rs2 = ~b; bus_if.i_imm = ~im;
         bus_if.i_cmp = (cmp_mode == 1) ? (c == 32) : (cmp_mode == 2) ? (c != 32) : 1'b0;
         rd_drv = (c <= 32) ? pat[c-1] : 1'b0;
         bus_if.i_rd_ready = (c == 33 + hold_extra);
         @(negedge clk);
         if (bus_if.o_en) r_en++;
         if (c <= 32) begin
            r_rs2[c-1] = bus_if.o_rs2;
            r_imm[c-1] = bus_if.o_imm;
         end
         if (bus_if.o_cnt0) begin r_cnt0++; r_cnt0_at = c; end
         if (bus_if.o_cnt_done) begin r_done++; r_done_at = c; end
         if (bus_if.o_rd_valid) begin
            if (!seen_valid) begin
               seen_valid = 1'b1; r_lat = c; r_rd = bus_if.o_rd; r_cmp = bus_if.o_cmp;
            end else if (bus_if.o_rd !== r_rd || bus_if.o_cmp !== r_cmp) begin
               r_stable = 1'b0;
            end
            if (bus_if.o_start_ready) r_rdy_hold++;
         end
         @(posedge clk); #2;
         c++;
      end
      bus_if.i_start_valid = 1'b0;
      bus_if.i_rd_ready = 1'b0;
      @(negedge clk);
      r_rdy_after = bus_if.o_start_ready;
   endtask

   // ---------------- scenarios ----------------
   int vcnt;
   initial begin
      total = 0; bad = 0;
      loop_en = 1'b0; rd_drv = 1'b0;
      bus_if.i_start_valid = 1'b0; bus_if.i_rd_ready = 1'b0; bus_if.i_cmp = 1'b0;
      bus_if.i_rs1 = '0; bus_if.i_rs2 = '0; bus_if.i_imm = '0;
      rst_n = 1'b0;

      // Reset held while every input toggles
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         bus_if.i_start_valid = 1'(i % 2 == 0);
         bus_if.i_rd_ready = 1'(i % 2);
         bus_if.i_cmp = 1'(i % 2 == 0);
         rd_drv = 1'(i % 2);
         bus_if.i_rs1 = $urandom; bus_if.i_rs2 = $urandom; bus_if.i_imm = $urandom;
      end
      @(negedge clk);
      chk1 ("rst_start_ready", bus_if.o_start_ready, 1'b1);
      chk1 ("rst_en",          bus_if.o_en,          1'b0);
      chk1 ("rst_rd_valid",    bus_if.o_rd_valid,    1'b0);
      chk32("rst_rd",          bus_if.o_rd,          32'h0);
      chk1 ("rst_cmp",         bus_if.o_cmp,         1'b0);
      @(posedge clk); #2;
      bus_if.i_start_valid = 1'b0; bus_if.i_rd_ready = 1'b0; bus_if.i_cmp = 1'b0;
      rst_n = 1'b1;

      // Loopback
      run_op(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0);
      chk32("lb_rd",        r_rd,                32'hDEADBEEF);
      chk32("lb_latency",   32'(r_lat),          32'd33);
      chk32("lb_en_cycles", 32'(r_en),           32'd32);
      chk32("lb_cnt0_cnt",  32'(r_cnt0),         32'd1);
      chk32("lb_cnt0_at",   32'(r_cnt0_at),      32'd1);
      chk32("lb_done_cnt",  32'(r_done),         32'd1);
      chk32("lb_done_at",   32'(r_done_at),      32'd32);
      chk1 ("lb_ready_after", r_rdy_after,       1'b1);

      // Bit order, with an independent result pattern
      run_op(32'h0, 32'h80000001, 32'h00000002, 32'h12345678, 1'b0, 0, 0, 1'b0);
      chk32("bo_rs2_bits", r_rs2, 32'h80000001);
      chk32("bo_imm_bits", r_imm, 32'h00000002);
      chk32("bo_rd",       r_rd,  32'h12345678);

      // Backpressure with start held valid throughout
      run_op(32'h0, 32'h0, 32'h0, 32'hA5C3F00F, 1'b0, 0, 10, 1'b1);
      chk32("bp_rd",         r_rd,              32'hA5C3F00F);
      chk32("bp_latency",    32'(r_lat),        32'd33);
      chk1 ("bp_stable",     r_stable,          1'b1);
      chk32("bp_ready_hold", 32'(r_rdy_hold),   32'd0);
      chk32("bp_en_cycles",  32'(r_en),         32'd32);
      chk1 ("bp_ready_after", r_rdy_after,      1'b1);

      // Compare capture on the last serial bit only
      run_op(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 0, 1'b0);
      chk1("cmp_last_only", r_cmp, 1'b1);
      run_op(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0, 1'b0);
      chk1 ("cmp_not_last", r_cmp, 1'b0);
      chk32("cmp2_rd",      r_rd,  32'hFFFFFFFF);

      // Mid-operation reset at RUN cycle 15
      @(posedge clk); #2;
      bus_if.i_start_valid = 1'b1; bus_if.i_rs1 = 32'hFFFF0000; loop_en = 1'b1;
      @(posedge clk); #2;
      bus_if.i_start_valid = 1'b0;
      repeat (14) begin @(posedge clk); #2; end
      chk1("mr_en_before", bus_if.o_en, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("mr_en_drop",    bus_if.o_en,          1'b0);
      chk1("mr_ready_rst",  bus_if.o_start_ready, 1'b1);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      vcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus_if.o_rd_valid) vcnt++;
      end
      chk32("mr_no_valid", 32'(vcnt), 32'd0);
      run_op(32'h00000005, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0);
      chk32("mr_next_rd",      r_rd,       32'h00000005);
      chk32("mr_next_latency", 32'(r_lat), 32'd33);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
